// File: rtl/seg7_pkg.sv
// Shared glyph table and decode helper for the seven-segment scan driver.
// Glyphs are stored active-high (bit0 = a ... bit6 = g); polarity is applied at the pins.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Entry n is the glyph for hex digit n; entry 0 sits in the least significant slot.
   localparam logic [15:0][6:0] SEG_GLYPHS = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return SEG_GLYPHS[nibble];
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble to active-high seven-segment glyph.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   assign glyph = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment scan driver with frame-boundary snapshots and per-slot blanking guard.
// Optional leading-zero suppression is compiled in when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int PAGES      = 4,
   parameter int CLK_DIV    = 40000,
   parameter int GUARD      = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic                                      enable,
   input  logic [((PAGES > 1) ? $clog2(PAGES) : 1)-1:0] page_sel,
   input  logic [PAGES*DIGITS*4-1:0]                 data,
   input  logic [PAGES*DIGITS-1:0]                   dp_in,
   output logic [6:0]                                seg,
   output logic                                      dp,
   output logic [DIGITS-1:0]                         select,
   output logic                                      frame_start
);

   localparam int PSW = (PAGES > 1) ? $clog2(PAGES) : 1;
   localparam int CW  = $clog2(CLK_DIV);
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic              POL      = (ACTIVE_LOW != 0);
   localparam logic [6:0]        SEG_IDLE = SEG_OFF ^ {7{POL}};
   localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{POL}};

   logic [CW-1:0]          div_cnt_q, div_cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [DIGITS*4-1:0]    frame_data_q, frame_data_d;
   logic [DIGITS-1:0]      frame_dp_q, frame_dp_d;
   logic                   frame_start_q, frame_start_d;
   logic [6:0]             seg_q, seg_d;
   logic                   dp_q, dp_d;
   logic [DIGITS-1:0]      select_q, select_d;

   logic                   tick;
   logic                   wrap;
   logic [PSW-1:0]         page_eff;
   logic [3:0]             cur_nibble;
   logic [6:0]             cur_glyph;
   logic [DIGITS-1:0]      onehot;
   logic [DIGITS-1:0]      lz_blank;

   seg7_decoder u_decoder (
      .nibble (cur_nibble),
      .glyph  (cur_glyph)
   );

`ifdef SEG7_LZ_BLANK_EN
   // A digit is blank when it and every higher digit are zero with no decimal point.
   logic zero_run;
   always_comb begin
      lz_blank = '0;
      zero_run = 1'b1;
      for (int i = DIGITS-1; i > 0; i--) begin
         zero_run    = zero_run && (frame_data_q[i*4 +: 4] == 4'h0) && !frame_dp_q[i];
         lz_blank[i] = zero_run;
      end
   end
`else
   assign lz_blank = '0;
`endif

   always_comb begin
      tick     = (div_cnt_q == CW'(CLK_DIV-1));
      wrap     = tick && (idx_q == IW'(DIGITS-1));
      page_eff = (int'(page_sel) < PAGES) ? page_sel : '0;

      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      idx_d     = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + 1'b1;
      end

      frame_data_d  = frame_data_q;
      frame_dp_d    = frame_dp_q;
      frame_start_d = wrap;
      if (wrap) begin
         frame_data_d = data[int'(page_eff)*DIGITS*4 +: DIGITS*4];
         frame_dp_d   = dp_in[int'(page_eff)*DIGITS +: DIGITS];
      end

      cur_nibble = frame_data_q[int'(idx_q)*4 +: 4];
      onehot     = '0;
      onehot[idx_q] = 1'b1;

      select_d = SEL_IDLE;
      seg_d    = SEG_IDLE;
      dp_d     = POL;
      // Select stays on for a blanked leading zero so the digit's duty cycle is unchanged.
      if (enable && (div_cnt_q >= CW'(GUARD))) begin
         select_d = onehot ^ SEL_IDLE;
         if (!lz_blank[idx_q]) begin
            seg_d = cur_glyph ^ {7{POL}};
            dp_d  = frame_dp_q[idx_q] ^ POL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         idx_q         <= '0;
         frame_data_q  <= '0;
         frame_dp_q    <= '0;
         frame_start_q <= 1'b0;
         seg_q         <= SEG_IDLE;
         dp_q          <= POL;
         select_q      <= SEL_IDLE;
      end else begin
         div_cnt_q     <= div_cnt_d;
         idx_q         <= idx_d;
         frame_data_q  <= frame_data_d;
         frame_dp_q    <= frame_dp_d;
         frame_start_q <= frame_start_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         select_q      <= select_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign select      = select_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display (DIGITS=4, PAGES=4, CLK_DIV=8, GUARD=2, active-low).
// Expectations for the blanked digits follow SEG7_LZ_BLANK_EN.
module tb_seg7_scan_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b1;
   logic [1:0]  page_sel = 2'd0;
   logic [63:0] data = '0;
   logic [15:0] dp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  select;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int rel = 0;
   int gap = 0;

`ifdef SEG7_LZ_BLANK_EN
   localparam logic [6:0] LZ_SEG = 7'h7F;
`else
   localparam logic [6:0] LZ_SEG = 7'h40;
`endif

   seg7_scan_display #(
      .DIGITS     (4),
      .PAGES      (4),
      .CLK_DIV    (8),
      .GUARD      (2),
      .ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .page_sel    (page_sel),
      .data        (data),
      .dp_in       (dp_in),
      .seg         (seg),
      .dp          (dp),
      .select      (select),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int page, input logic [15:0] nibs, input logic [3:0] dps);
      data[page*16 +: 16] = nibs;
      dp_in[page*4 +: 4]  = dps;
   endtask

   // rel counts falling edges since the last observed frame_start.
   task automatic stepTo(input int n);
      while (rel < n) begin
         @(negedge clk);
         rel++;
      end
   endtask

   task automatic waitFrameStart(output int cycles);
      int budget;
      budget = 0;
      do begin
         @(negedge clk);
         rel++;
         budget++;
      end while (!frame_start && budget < 80);
      cycles = rel;
      rel = 0;
   endtask

   task automatic checkDigit(input string tag, input int k, input logic [6:0] exp_seg, input logic exp_dp);
      logic [3:0] exp_sel;
      exp_sel    = 4'hF;
      exp_sel[k] = 1'b0;
      stepTo(8*k + 1);
      checkOutput($sformatf("%s_d%0d_guard_sel", tag, k), 32'(select), 32'h0000000F);
      checkOutput($sformatf("%s_d%0d_guard_seg", tag, k), 32'(seg), 32'h0000007F);
      stepTo(8*k + 3);
      checkOutput($sformatf("%s_d%0d_sel", tag, k), 32'(select), 32'(exp_sel));
      checkOutput($sformatf("%s_d%0d_seg", tag, k), 32'(seg), 32'(exp_seg));
      checkOutput($sformatf("%s_d%0d_dp", tag, k), 32'(dp), 32'(exp_dp));
      stepTo(8*k + 7);
      checkOutput($sformatf("%s_d%0d_seg_late", tag, k), 32'(seg), 32'(exp_seg));
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_sel"}, 32'(select), 32'h0000000F);
      checkOutput({tag, "_seg"}, 32'(seg), 32'h0000007F);
      checkOutput({tag, "_dp"}, 32'(dp), 32'h00000001);
      checkOutput({tag, "_fs"}, 32'(frame_start), 32'h00000000);
   endtask

   task automatic resetRelease(input string tag);
      @(negedge clk);
      rst_n = 1'b1;
      rel = 0;
      stepTo(1);
      checkOutput({tag, "_first_guard_sel"}, 32'(select), 32'h0000000F);
      stepTo(3);
      checkOutput({tag, "_first_sel"}, 32'(select), 32'h0000000E);
      checkOutput({tag, "_first_seg"}, 32'(seg), 32'h00000040);
      checkOutput({tag, "_first_dp"}, 32'(dp), 32'h00000001);
      waitFrameStart(gap);
      checkOutput({tag, "_first_fs_gap"}, gap, 32);
      stepTo(1);
      checkOutput({tag, "_fs_width"}, 32'(frame_start), 32'h00000000);
   endtask

   initial begin
      applyStimulus(0, 16'h1234, 4'h0);
      applyStimulus(1, 16'hABCD, 4'h0);
      #1 rst_n = 1'b0;
      #2 checkIdle("reset");
      resetRelease("rst1");

      checkDigit("p0", 0, 7'h19, 1'b1);
      checkDigit("p0", 1, 7'h30, 1'b1);
      checkDigit("p0", 2, 7'h24, 1'b1);
      checkDigit("p0", 3, 7'h79, 1'b1);

      // Page switch while digit 1 is being scanned.
      waitFrameStart(gap);
      checkOutput("frame_gap_a", gap, 32);
      checkDigit("sw", 0, 7'h19, 1'b1);
      stepTo(9);
      page_sel = 2'd1;
      checkDigit("sw", 1, 7'h30, 1'b1);
      checkDigit("sw", 2, 7'h24, 1'b1);
      checkDigit("sw", 3, 7'h79, 1'b1);
      waitFrameStart(gap);
      checkOutput("frame_gap_b", gap, 32);
      checkOutput("sw_hold_at_fs", 32'(seg), 32'h00000079);

      // Data change mid-frame stays invisible until the next snapshot.
      checkDigit("p1", 0, 7'h21, 1'b1);
      checkDigit("p1", 1, 7'h46, 1'b1);
      applyStimulus(1, 16'h5678, 4'h0);
      checkDigit("p1", 2, 7'h03, 1'b1);
      checkDigit("p1", 3, 7'h08, 1'b1);
      waitFrameStart(gap);
      checkOutput("frame_gap_c", gap, 32);
      checkOutput("dc_hold_at_fs", 32'(seg), 32'h00000008);
      checkDigit("dc", 0, 7'h00, 1'b1);
      checkDigit("dc", 1, 7'h78, 1'b1);
      checkDigit("dc", 2, 7'h02, 1'b1);
      checkDigit("dc", 3, 7'h12, 1'b1);

      // Enable dropped mid-slot; scanning and snapshots continue.
      waitFrameStart(gap);
      stepTo(5);
      checkOutput("en_lit_sel", 32'(select), 32'h0000000E);
      checkOutput("en_lit_seg", 32'(seg), 32'h00000000);
      enable = 1'b0;
      stepTo(6);
      checkOutput("en_off_sel", 32'(select), 32'h0000000F);
      checkOutput("en_off_seg", 32'(seg), 32'h0000007F);
      checkOutput("en_off_dp", 32'(dp), 32'h00000001);
      stepTo(12);
      checkOutput("en_off_d1_sel", 32'(select), 32'h0000000F);
      waitFrameStart(gap);
      checkOutput("en_off_gap_a", gap, 32);
      waitFrameStart(gap);
      checkOutput("en_off_gap_b", gap, 32);
      enable = 1'b1;

      // Asynchronous reset in the middle of a lit slot.
      stepTo(4);
      checkOutput("rst2_lit_sel", 32'(select), 32'h0000000E);
      checkOutput("rst2_lit_seg", 32'(seg), 32'h00000000);
      #2 rst_n = 1'b0;
      #1 checkIdle("rst2_async");
      resetRelease("rst2");
      checkDigit("rst2", 0, 7'h00, 1'b1);

      // Leading-zero patterns on page 0.
      page_sel = 2'd0;
      applyStimulus(0, 16'h0050, 4'h0);
      waitFrameStart(gap);
      checkOutput("lz_gap", gap, 32);
      checkDigit("lz50", 0, 7'h40, 1'b1);
      checkDigit("lz50", 1, 7'h12, 1'b1);
      checkDigit("lz50", 2, LZ_SEG, 1'b1);
      checkDigit("lz50", 3, LZ_SEG, 1'b1);
      applyStimulus(0, 16'h0000, 4'h0);
      waitFrameStart(gap);
      checkDigit("lz0", 0, 7'h40, 1'b1);
      checkDigit("lz0", 1, LZ_SEG, 1'b1);
      checkDigit("lz0", 2, LZ_SEG, 1'b1);
      checkDigit("lz0", 3, LZ_SEG, 1'b1);
      applyStimulus(0, 16'h0000, 4'b0100);
      waitFrameStart(gap);
      checkDigit("lzdp", 0, 7'h40, 1'b1);
      checkDigit("lzdp", 1, 7'h40, 1'b1);
      checkDigit("lzdp", 2, 7'h40, 1'b0);
      checkDigit("lzdp", 3, LZ_SEG, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
- Parametrised multiplexed seven-segment scan driver. Scans DIGITS digits from one of PAGES pre-packed hex data pages.
- Page and data are latched only at frame boundaries, so the display never tears. Each digit change gets a blanking guard interval to suppress ghosting.
- Sits between the CPU debug/observation buses and the board display pins.
- Generation 2 of the board display path: adds reset, a run-time enable, decimal points, glitch-free page switching and polarity control.

Parameters:
- DIGITS, 4: number of digits (1..8). Width of select.
- PAGES, 4: number of selectable data pages (>=1).
- CLK_DIV, 40000: clk cycles per digit slot (>=4).
- GUARD, 16: clk cycles at the start of each slot with all digits off (1..CLK_DIV-2).
- ACTIVE_LOW, 1: 1 means seg, dp and select are active-low; 0 means active-high.

Ports:
- clk, input, 1: system clock; all state on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- enable, input, 1: 0 forces all digits off; scanning continues.
- page_sel, input, max(1,$clog2(PAGES)): requested page; values >= PAGES are treated as page 0.
- data, input, PAGES*DIGITS*4: page p, digit i nibble = data[(p*DIGITS+i)*4 +: 4].
- dp_in, input, PAGES*DIGITS: page p, digit i decimal point = dp_in[p*DIGITS+i].
- seg, output, 7: segments, bit0 = a ... bit6 = g.
- dp, output, 1: decimal point.
- select, output, DIGITS: digit enables; bit i drives digit i.
- frame_start, output, 1: one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Reset (async assert, sync release): div_cnt=0, idx=0, page_q=0, frame_data=0, frame_dp=0, frame_start=0. seg, dp and select all at the inactive level (ACTIVE_LOW=1 gives seg=7'h7F, dp=1, select=all ones).
- Prescaler: div_cnt counts 0..CLK_DIV-1 and wraps. tick = (div_cnt==CLK_DIV-1).
- On tick, idx advances mod DIGITS (ascending 0..DIGITS-1).
- Frame snapshot: on a tick where idx==DIGITS-1 (wrap to 0):
  - page_q <= page_sel.
  - frame_data <= data page of page_sel.
  - frame_dp <= dp_in page of page_sel.
  - frame_start pulses in the same cycle as the update.
- Changes to page_sel, data or dp_in mid-frame are invisible until the next snapshot.
- After reset the first frame shows zeros until the first wrap (DIGITS*CLK_DIV cycles).
- Outputs are registered and updated every clk from the current (div_cnt, idx, frame_data, frame_dp, enable), so they lag that state by 1 cycle.
- Guard: when div_cnt < GUARD or enable==0:
  - select all inactive, seg all inactive, dp inactive.
- Otherwise:
  - select is one-hot active at bit idx.
  - seg = decode(frame_data nibble idx); dp = frame_dp[idx].
- Decode (active-high form, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - When ACTIVE_LOW=1, the output is inverted.
- Digit slot timing: GUARD cycles dark, then CLK_DIV-GUARD cycles lit. Full frame = DIGITS*CLK_DIV cycles.
- enable has no effect on counters, snapshots or frame_start.
- Reset asserted mid-slot: outputs go inactive immediately (asynchronously). Scanning restarts at idx 0, div_cnt 0.

Optional Feature:
- Macro SEG7_LZ_BLANK_EN.
- Defined: leading-zero suppression. Digit i (i>0) is blanked (seg inactive, dp inactive, select still active) when all of the following hold in the frame snapshot:
  - every nibble i..DIGITS-1 is 0, and
  - every dp bit i..DIGITS-1 is 0.
- Digit 0 is never blanked. Blanking is computed from the snapshot, not from live inputs.
- Undefined: every digit always shows its hex glyph.

Decomposition:
- Package seg7_pkg: the 16-entry glyph constant table (active-high), a hex_to_seg function, and the SEG_OFF constant.
- One sub-module, seg7_decoder: combinational nibble -> 7-bit active-high glyph. The top applies polarity.
- The top holds prescaler, index counter, snapshot registers, guard/blank logic and output registers.

Test Plan:
All scenarios use DIGITS=4, PAGES=4, CLK_DIV=8, GUARD=2, ACTIVE_LOW=1.
1. Reset, then page 0 data=16'h1234, page_sel=0, enable=1.
   - First frame: select=4'b1110 lit with seg=7'h40 (glyph 0).
   - After the first frame_start, slots show select 1110/1101/1011/0111 with seg 7'h19 (4), 7'h30 (3), 7'h24 (2), 7'h79 (1).
   - Each slot is 2 cycles all-off, then 6 cycles lit.
2. Change page_sel 0->1 (page1=16'hABCD) while idx==1.
   - Digits 2 and 3 still show 2, 1.
   - frame_start pulses, then digit 0 shows D (7'h21), and so on.
3. Change data mid-frame.
   - No seg change until the cycle after frame_start.
4. enable=0 mid-slot.
   - select=4'hF and seg=7'h7F one cycle later.
   - frame_start pulse spacing is unchanged (32 cycles).
5. rst_n low mid-lit slot.
   - select=4'hF and seg=7'h7F with no clock edge.
   - After release, scanning restarts at digit 0 and the first frame_start comes 32 cycles later.
6. With SEG7_LZ_BLANK_EN:
   - data=16'h0050: digits 3 and 2 show seg=7'h7F with select active; digit 1 shows 5 (7'h12); digit 0 shows 0.
   - data=0: only digit 0 is lit.
   - dp_in[2]=1 with data=0: digits 2, 1 and 0 are lit.
